// File: rtl/sccb_pkg.sv
// Shared state encoding and table constants for the SCCB register-init sequencer.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RELEASE,
    ST_DELAY,
    ST_FINISH
  } state_e;

  localparam logic [15:0] END_MARKER   = 16'hFFFF;
  localparam logic [7:0]  DELAY_PREFIX = 8'hFE;
  localparam logic [7:0]  DEV_ID_DFLT  = 8'h42;

endpackage

// File: rtl/sccb_init_seq_if.sv
// Request/completion bundle between the init sequencer (master) and an SCCB core (slave).
interface sccb_init_seq_if;

  logic       sccb_start;
  logic       sccb_rw;
  logic [7:0] sccb_ip_addr;
  logic [7:0] sccb_sub_addr;
  logic [7:0] sccb_data_in;
  logic       sccb_done;

  modport master (
    output sccb_start, sccb_rw, sccb_ip_addr, sccb_sub_addr, sccb_data_in,
    input  sccb_done
  );

  modport slave (
    input  sccb_start, sccb_rw, sccb_ip_addr, sccb_sub_addr, sccb_data_in,
    output sccb_done
  );

endinterface

// File: rtl/sccb_delay_timer.sv
// Shared cycle counter: cleared on request, counts while enabled, flags when it sits on 'last'.
module sccb_delay_timer #(
  parameter int W = 8
) (
  input  logic         PCLK,
  input  logic         PRESETN,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         hit
);

  logic [W-1:0] cnt;

  assign hit = (cnt == last);

  // Holds on 'last' so a late consumer still sees hit.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)       cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !hit) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/sccb_init_seq.sv
// Walks an external register table and issues SCCB writes, with delay entries and timeout.
module sccb_init_seq
  import sccb_pkg::*;
#(
  parameter int          NUM_ENTRIES    = 64,
  parameter logic [7:0]  DEV_ID         = DEV_ID_DFLT,
  parameter int          TIMEOUT_CYCLES = 100_000,
  parameter int          DELAY_UNIT     = 50_000,
  localparam int         AW             = $clog2(NUM_ENTRIES)
) (
  input  logic                   PCLK,
  input  logic                   PRESETN,
  input  logic                   go,
  input  logic                   abort,
  output logic [AW-1:0]          tbl_addr,
  input  logic [15:0]            tbl_data,
  sccb_init_seq_if.master        sccb,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [AW:0]            count
);

  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int CNT_MAX = (DLY_MAX > TIMEOUT_CYCLES) ? DLY_MAX : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(CNT_MAX + 1);

  state_e        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt, tbl_addr_nxt;
  logic          start_q, start_nxt;
  logic [7:0]    ip_q, ip_nxt, sub_q, sub_nxt, dat_q, dat_nxt;
  logic          busy_nxt, done_nxt, err_nxt;
  logic [AW:0]   count_nxt;
  logic [TW-1:0] dly_last, dly_last_nxt;
  logic          tmr_clr, tmr_en, tmr_hit;
  logic [TW-1:0] tmr_last;
  logic          advance, finish;

  sccb_delay_timer #(.W(TW)) u_timer (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .last    (tmr_last),
    .hit     (tmr_hit)
  );

  assign sccb.sccb_start    = start_q;
  assign sccb.sccb_rw       = 1'b0;
  assign sccb.sccb_ip_addr  = ip_q;
  assign sccb.sccb_sub_addr = sub_q;
  assign sccb.sccb_data_in  = dat_q;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state    <= ST_IDLE;
      idx      <= '0;
      tbl_addr <= '0;
      start_q  <= 1'b0;
      ip_q     <= DEV_ID;
      sub_q    <= '0;
      dat_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
      dly_last <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      tbl_addr <= tbl_addr_nxt;
      start_q  <= start_nxt;
      ip_q     <= ip_nxt;
      sub_q    <= sub_nxt;
      dat_q    <= dat_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      count    <= count_nxt;
      dly_last <= dly_last_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    tbl_addr_nxt = tbl_addr;
    start_nxt    = start_q;
    ip_nxt       = ip_q;
    sub_nxt      = sub_q;
    dat_nxt      = dat_q;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = err;
    count_nxt    = count;
    dly_last_nxt = dly_last;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    tmr_last     = dly_last;
    advance      = 1'b0;
    finish       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (go) begin
          idx_nxt      = '0;
          tbl_addr_nxt = '0;
          count_nxt    = '0;
          err_nxt      = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (tbl_data == END_MARKER) begin
          finish = 1'b1;
        end else if (tbl_data[15:8] == DELAY_PREFIX) begin
          // A zero tick count skips the DELAY state entirely.
          if (tbl_data[7:0] == 8'd0) begin
            advance = 1'b1;
          end else begin
            dly_last_nxt = TW'(tbl_data[7:0]) * TW'(DELAY_UNIT) - TW'(1);
            tmr_clr      = 1'b1;
            state_nxt    = ST_DELAY;
          end
        end else begin
          sub_nxt   = tbl_data[15:8];
          dat_nxt   = tbl_data[7:0];
          ip_nxt    = DEV_ID;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_nxt = 1'b1;
        tmr_clr   = 1'b1;
        state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tmr_en   = 1'b1;
        tmr_last = TW'(TIMEOUT_CYCLES - 1);
        if (sccb.sccb_done) begin
          start_nxt = 1'b0;
          count_nxt = count + 1'b1;
          state_nxt = ST_RELEASE;
        end else if (tmr_hit) begin
          err_nxt = 1'b1;
          finish  = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!sccb.sccb_done) advance = 1'b1;
      end
      ST_DELAY: begin
        tmr_en = 1'b1;
        if (tmr_hit) advance = 1'b1;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    // The last table slot ends the walk instead of wrapping the index.
    if (advance) begin
      if (idx == AW'(NUM_ENTRIES - 1)) begin
        finish = 1'b1;
      end else begin
        idx_nxt      = idx + 1'b1;
        tbl_addr_nxt = idx + 1'b1;
        state_nxt    = ST_FETCH;
      end
    end

    // Abort beats a simultaneous timeout, so err keeps its prior value.
    if (abort && state != ST_IDLE && state != ST_FINISH) begin
      finish  = 1'b1;
      err_nxt = err;
    end

    if (finish) begin
      state_nxt = ST_FINISH;
      start_nxt = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b1;
    end
  end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed plus randomized bench for sccb_init_seq with a table-walk reference model.
module tb_sccb_init_seq;

  localparam int         NE  = 4;
  localparam int         DU  = 10;
  localparam int         TO  = 50;
  localparam logic [7:0] DEV = 8'h42;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic        busy, done, err;
  logic [2:0]  count;

  sccb_init_seq_if sif ();

  sccb_init_seq #(
    .NUM_ENTRIES    (NE),
    .DEV_ID         (DEV),
    .TIMEOUT_CYCLES (TO),
    .DELAY_UNIT     (DU)
  ) dut (
    .PCLK     (PCLK),
    .PRESETN  (PRESETN),
    .go       (go),
    .abort    (abort),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .sccb     (sif),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .count    (count)
  );

  always #5 PCLK = ~PCLK;

  // Registered table ROM.
  logic [15:0] rom [NE];
  always @(posedge PCLK) tbl_data <= rom[tbl_addr];

  // SCCB core model: done rises core_lat cycles after start, falls once start is low.
  int   core_lat  = 20;
  bit   core_dead = 1'b0;
  int   core_cnt  = 0;
  logic core_done = 1'b0;
  assign sif.sccb_done = core_done;

  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else if (core_done) begin
      if (!sif.sccb_start) core_done <= 1'b0;
    end else if (sif.sccb_start && !core_dead) begin
      if (core_cnt >= core_lat - 1) begin
        core_done <= 1'b1;
        core_cnt  <= 0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end else begin
      core_cnt <= 0;
    end
  end

  // Monitor: records each write request and start edges, counts done-high cycles.
  int          cyc = 0;
  logic [15:0] wr_q [$];
  int          rise_q [$];
  int          fall_q [$];
  int          done_pulses = 0;
  int          bad_fields = 0;
  logic        start_d = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    if (sif.sccb_start === 1'b1 && start_d !== 1'b1) begin
      wr_q.push_back({sif.sccb_sub_addr, sif.sccb_data_in});
      rise_q.push_back(cyc);
      if (sif.sccb_ip_addr !== DEV || sif.sccb_rw !== 1'b0) bad_fields++;
    end
    if (sif.sccb_start !== 1'b1 && start_d === 1'b1) fall_q.push_back(cyc);
    if (done === 1'b1) done_pulses++;
    start_d = sif.sccb_start;
  end

  // Reference: the writes a table walk should produce.
  logic [15:0] exp_q [$];
  function automatic void model_walk();
    exp_q.delete();
    for (int i = 0; i < NE; i++) begin
      if (rom[i] == 16'hFFFF) break;
      if (rom[i][15:8] == 8'hFE) continue;
      exp_q.push_back(rom[i]);
    end
  endfunction

  function automatic logic [15:0] rand_wr();
    logic [7:0] s, d;
    s = 8'($urandom_range(0, 8'hFD));
    d = 8'($urandom);
    return {s, d};
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_go();
    wr_q.delete();
    rise_q.delete();
    fall_q.delete();
    done_pulses = 0;
    bad_fields  = 0;
    @(negedge PCLK);
    go = 1'b1;
    @(negedge PCLK);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    repeat (2) @(negedge PCLK);
  endtask

  task automatic cmp_writes(input string tag);
    model_walk();
    check({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check({tag, "_wr"}, wr_q[i], exp_q[i]);
    check({tag, "_count"}, count, exp_q.size());
    check({tag, "_err"}, err, 0);
    check({tag, "_pulses"}, done_pulses, 1);
    check({tag, "_fields"}, bad_fields, 0);
  endtask

  task automatic walk(input string tag);
    bit ok;
    pulse_go();
    wait_done(3000, ok);
    check({tag, "_finished"}, ok, 1);
    cmp_writes(tag);
  endtask

  initial begin
    bit ok;
    bit seen;
    int g0, g2, base;

    // Reset values
    repeat (3) @(negedge PCLK);
    check("rst_start", sif.sccb_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_ip", sif.sccb_ip_addr, DEV);
    check("rst_sub", sif.sccb_sub_addr, 0);
    check("rst_data", sif.sccb_data_in, 0);
    check("rst_rw", sif.sccb_rw, 0);
    PRESETN = 1'b1;
    repeat (2) @(negedge PCLK);

    // Two writes then end marker
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
    core_lat = 20;
    pulse_go();
    check("basic_busy_after_go", busy, 1);
    wait_done(3000, ok);
    check("basic_finished", ok, 1);
    cmp_writes("basic");
    check("basic_busy_end", busy, 0);

    // Delay entry: FE02 must add exactly 2*DU cycles over FE00
    core_lat = 3;
    rom[0] = 16'h1280; rom[1] = 16'hFE00; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
    walk("dly0");
    g0 = (rise_q.size() >= 2 && fall_q.size() >= 1) ? rise_q[1] - fall_q[0] : -1000;
    rom[1] = 16'hFE02;
    walk("dly2");
    g2 = (rise_q.size() >= 2 && fall_q.size() >= 1) ? rise_q[1] - fall_q[0] : -1000;
    check("dly_extra", g2 - g0, 2 * DU);
    check("dly_gap_min", (g2 >= 2 * DU) ? 1 : 0, 1);

    // Timeout
    core_dead = 1'b1;
    rom[0] = 16'h1280; rom[1] = 16'hFFFF;
    pulse_go();
    wait_done(3000, ok);
    check("to_finished", ok, 1);
    check("to_start_len", (rise_q.size() == 1 && fall_q.size() == 1) ? fall_q[0] - rise_q[0] : -1, TO);
    check("to_err", err, 1);
    check("to_pulses", done_pulses, 1);
    check("to_count", count, 0);
    check("to_start_low", sif.sccb_start, 0);
    core_dead = 1'b0;
    core_lat  = 5;
    walk("to_clear");

    // Abort during second write's wait
    core_lat = 20;
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge PCLK);
      if (rise_q.size() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("ab_reached", ok, 1);
    repeat (5) @(negedge PCLK);
    abort = 1'b1;
    @(posedge PCLK);
    #1;
    check("ab_start_drop", sif.sccb_start, 0);
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge PCLK);
    end
    abort = 1'b0;
    check("ab_done_pulse", seen, 1);
    check("ab_count", count, 1);
    check("ab_err", err, 0);
    repeat (5) @(negedge PCLK);
    check("ab_busy", busy, 0);

    // Abort on the same cycle the core reports done
    core_lat = 7;
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (sif.sccb_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    check("abd_reached", ok, 1);
    abort = 1'b1;
    @(negedge PCLK);
    abort = 1'b0;
    wait_done(20, ok);
    check("abd_finished", ok, 1);
    check("abd_count", count, 1);
    check("abd_nwr", wr_q.size(), 1);
    check("abd_err", err, 0);

    // Full table without end marker; go while busy is ignored
    for (int i = 0; i < NE; i++) rom[i] = rand_wr();
    core_lat = $urandom_range(1, 6);
    pulse_go();
    repeat (3) @(negedge PCLK);
    check("full_busy_mid", busy, 1);
    go = 1'b1;
    @(negedge PCLK);
    go = 1'b0;
    wait_done(3000, ok);
    check("full_finished", ok, 1);
    cmp_writes("full");
    repeat (10) @(negedge PCLK);
    check("full_no_restart", busy, 0);
    check("full_nwr_after", wr_q.size(), NE);

    // Randomized tables
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NE; i++) begin
        case ($urandom_range(0, 9))
          0, 1:    rom[i] = {8'hFE, 8'($urandom_range(0, 3))};
          2:       rom[i] = 16'hFFFF;
          default: rom[i] = rand_wr();
        endcase
      end
      core_lat = $urandom_range(1, 8);
      walk("rand");
    end

    // Reset in the middle of a wait
    core_lat = 30;
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
    pulse_go();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sif.sccb_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    check("mr_reached", ok, 1);
    repeat (5) @(negedge PCLK);
    base = done_pulses;
    #2 PRESETN = 1'b0;
    #1;
    check("mr_start", sif.sccb_start, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_count", count, 0);
    check("mr_tbl_addr", tbl_addr, 0);
    check("mr_ip", sif.sccb_ip_addr, DEV);
    check("mr_sub", sif.sccb_sub_addr, 0);
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
    repeat (10) @(negedge PCLK);
    check("mr_no_done", done_pulses - base, 0);
    core_lat = 4;
    walk("mr_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
